// File: rtl/ref_price_pipe.sv
// ref_price_pipe
//   Multi-channel reservation-price engine:
//     ref = price - q * gamma * sigma * (T - t)
//   in signed fixed point, with per-channel gamma / T held in a small
//   configuration register file. Four register stages share one stall
//   signal, so the block accepts one transaction per cycle and the result
//   appears four cycles after acceptance when downstream is ready.
//
// Ports
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_cfg_*                per-channel gamma (signed FP) / T (unsigned int) write
//   i_valid / o_ready      input handshake
//   i_channel, i_curr_price, i_curr_time, i_inventory_state, i_volatility
//                          transaction operands
//   o_valid / i_ready      output handshake
//   o_channel, o_ref_price, o_expired, o_sat
//                          result, expiry flag and sticky saturation flag
module ref_price_pipe #(
  parameter int FP_WORD_SIZE = 64,
  parameter int FRAC_BITS    = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W         = $clog2(NUM_CHANNELS)
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_cfg_we,
  input  logic [CH_W-1:0]         i_cfg_ch,
  input  logic [FP_WORD_SIZE-1:0] i_cfg_risk_factor,
  input  logic [DATA_WIDTH-1:0]   i_cfg_terminal_time,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [CH_W-1:0]         i_channel,
  input  logic [DATA_WIDTH-1:0]   i_curr_price,
  input  logic [DATA_WIDTH-1:0]   i_curr_time,
  input  logic [FP_WORD_SIZE-1:0] i_inventory_state,
  input  logic [FP_WORD_SIZE-1:0] i_volatility,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [CH_W-1:0]         o_channel,
  output logic [FP_WORD_SIZE-1:0] o_ref_price,
  output logic                    o_expired,
  output logic                    o_sat
);

  localparam int W  = FP_WORD_SIZE;
  // Wide enough for an integer shifted into FP position plus one bit,
  // so the overflow compare against FP_MAX is exact.
  localparam int UW = ((DATA_WIDTH + FRAC_BITS) > W ? (DATA_WIDTH + FRAC_BITS) : W) + 1;

  localparam logic [W-1:0]  FP_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  FP_MIN   = {1'b1, {(W-1){1'b0}}};
  localparam logic [UW-1:0] FP_MAX_U = (UW'(1) << (W-1)) - UW'(1);

  typedef struct packed {
    logic         sat;
    logic [W-1:0] val;
  } mul_t;

  // Full-width product, floor shift back to FP scale, saturate to W bits.
  function automatic mul_t fp_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [2*W-1:0] xe, ye, prod, shr;
    mul_t r;
    xe   = {{W{x[W-1]}}, x};
    ye   = {{W{y[W-1]}}, y};
    prod = xe * ye;
    shr  = prod >>> FRAC_BITS;
    if ((&shr[2*W-1:W-1]) || !(|shr[2*W-1:W-1])) begin
      r.sat = 1'b0;
      r.val = shr[W-1:0];
    end else begin
      r.sat = 1'b1;
      r.val = shr[2*W-1] ? FP_MIN : FP_MAX;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- config
  logic [W-1:0]          gamma_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0] term_q  [NUM_CHANNELS];

  // Out-of-range channel numbers simply match no entry.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        gamma_q[c] <= '0;
        term_q[c]  <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (i_cfg_we && (i_cfg_ch == CH_W'(c))) begin
          gamma_q[c] <= i_cfg_risk_factor;
          term_q[c]  <= i_cfg_terminal_time;
        end
      end
    end
  end

  // ---------------------------------------------------------------- stage 1
  logic [W-1:0]          gamma_d;
  logic [DATA_WIDTH-1:0] term_d;

  // Reads the registered file, so a same-cycle write is not yet visible.
  always_comb begin
    gamma_d = '0;
    term_d  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (i_channel == CH_W'(c)) begin
        gamma_d = gamma_q[c];
        term_d  = term_q[c];
      end
    end
  end

  logic                  expired_d;
  logic [DATA_WIDTH-1:0] time_left_d;
  logic [UW-1:0]         tau_wide_d, price_wide_d;
  logic                  tau_sat_d, price_sat_d;
  logic [W-1:0]          tau_d, price_fp_d;
  mul_t                  a_d;

  assign expired_d    = (i_curr_time >= term_d);
  assign time_left_d  = expired_d ? '0 : (term_d - i_curr_time);
  assign tau_wide_d   = UW'(time_left_d) << FRAC_BITS;
  assign price_wide_d = UW'(i_curr_price) << FRAC_BITS;
  assign tau_sat_d    = (tau_wide_d > FP_MAX_U);
  assign price_sat_d  = (price_wide_d > FP_MAX_U);
  assign tau_d        = tau_sat_d   ? FP_MAX : tau_wide_d[W-1:0];
  assign price_fp_d   = price_sat_d ? FP_MAX : price_wide_d[W-1:0];
  assign a_d          = fp_mul(i_inventory_state, gamma_d);

  // ---------------------------------------------------------------- pipeline
  logic            s1_valid_q, s2_valid_q, s3_valid_q, s4_valid_q;
  logic [CH_W-1:0] s1_ch_q, s2_ch_q, s3_ch_q, s4_ch_q;
  logic            s1_exp_q, s2_exp_q, s3_exp_q, s4_exp_q;
  logic            s1_sat_q, s2_sat_q, s3_sat_q, s4_sat_q;
  logic [W-1:0]    s1_price_q, s2_price_q, s3_price_q;
  logic [W-1:0]    s1_tau_q, s2_tau_q;
  logic [W-1:0]    s1_a_q, s1_sigma_q, s2_b_q, s3_adj_q, s4_ref_q;

  logic advance;
  assign advance = !s4_valid_q || i_ready;

  mul_t b_d, adj_d;
  assign b_d   = fp_mul(s1_a_q, s1_sigma_q);
  assign adj_d = fp_mul(s2_b_q, s2_tau_q);

  // One guard bit: price_fp is non-negative, so the difference lands in
  // [-(2^(W-1)), 2^W) and only needs sign + overflow inspection.
  logic signed [W:0] diff_d;
  logic [W-1:0]      ref_d;
  logic              clamp_d;

  always_comb begin
    diff_d  = {s3_price_q[W-1], s3_price_q} - {s3_adj_q[W-1], s3_adj_q};
    ref_d   = diff_d[W-1:0];
    clamp_d = 1'b0;
    if (diff_d[W]) begin
      ref_d   = '0;
      clamp_d = 1'b1;
    end else if (diff_d[W-1]) begin
      ref_d   = FP_MAX;
      clamp_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_valid_q <= 1'b0; s2_valid_q <= 1'b0; s3_valid_q <= 1'b0; s4_valid_q <= 1'b0;
      s1_ch_q    <= '0;   s2_ch_q    <= '0;   s3_ch_q    <= '0;   s4_ch_q    <= '0;
      s1_exp_q   <= 1'b0; s2_exp_q   <= 1'b0; s3_exp_q   <= 1'b0; s4_exp_q   <= 1'b0;
      s1_sat_q   <= 1'b0; s2_sat_q   <= 1'b0; s3_sat_q   <= 1'b0; s4_sat_q   <= 1'b0;
      s1_price_q <= '0;   s2_price_q <= '0;   s3_price_q <= '0;
      s1_tau_q   <= '0;   s2_tau_q   <= '0;
      s1_a_q     <= '0;   s1_sigma_q <= '0;
      s2_b_q     <= '0;   s3_adj_q   <= '0;   s4_ref_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= i_valid;
      s1_ch_q    <= i_channel;
      s1_exp_q   <= expired_d;
      s1_sat_q   <= tau_sat_d | price_sat_d | a_d.sat;
      s1_price_q <= price_fp_d;
      s1_tau_q   <= tau_d;
      s1_a_q     <= a_d.val;
      s1_sigma_q <= i_volatility;

      s2_valid_q <= s1_valid_q;
      s2_ch_q    <= s1_ch_q;
      s2_exp_q   <= s1_exp_q;
      s2_sat_q   <= s1_sat_q | b_d.sat;
      s2_price_q <= s1_price_q;
      s2_tau_q   <= s1_tau_q;
      s2_b_q     <= b_d.val;

      s3_valid_q <= s2_valid_q;
      s3_ch_q    <= s2_ch_q;
      s3_exp_q   <= s2_exp_q;
      s3_sat_q   <= s2_sat_q | adj_d.sat;
      s3_price_q <= s2_price_q;
      s3_adj_q   <= adj_d.val;

      s4_valid_q <= s3_valid_q;
      s4_ch_q    <= s3_ch_q;
      s4_exp_q   <= s3_exp_q;
      s4_sat_q   <= s3_sat_q | clamp_d;
      s4_ref_q   <= ref_d;
    end
  end

  assign o_ready     = advance;
  assign o_valid     = s4_valid_q;
  assign o_channel   = s4_ch_q;
  assign o_ref_price = s4_ref_q;
  assign o_expired   = s4_exp_q;
  assign o_sat       = s4_sat_q;

endmodule

// File: tb/tb_ref_price_pipe.sv
// Scoreboard bench for ref_price_pipe (default 64/32 FP, 4 channels).
module tb_ref_price_pipe;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_ch;
  logic [63:0] i_cfg_risk_factor;
  logic [31:0] i_cfg_terminal_time;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_channel;
  logic [31:0] i_curr_price;
  logic [31:0] i_curr_time;
  logic [63:0] i_inventory_state;
  logic [63:0] i_volatility;
  logic        o_valid;
  logic        i_ready;
  logic [1:0]  o_channel;
  logic [63:0] o_ref_price;
  logic        o_expired;
  logic        o_sat;

  always #5 i_clk = ~i_clk;

  ref_price_pipe dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
    .i_cfg_risk_factor(i_cfg_risk_factor), .i_cfg_terminal_time(i_cfg_terminal_time),
    .i_valid(i_valid), .o_ready(o_ready), .i_channel(i_channel),
    .i_curr_price(i_curr_price), .i_curr_time(i_curr_time),
    .i_inventory_state(i_inventory_state), .i_volatility(i_volatility),
    .o_valid(o_valid), .i_ready(i_ready), .o_channel(o_channel),
    .o_ref_price(o_ref_price), .o_expired(o_expired), .o_sat(o_sat)
  );

  localparam logic [63:0] ONE  = 64'h0000_0001_0000_0000;
  localparam logic [63:0] HALF = 64'h0000_0000_8000_0000;
  localparam logic [63:0] TWO  = 64'h0000_0002_0000_0000;
  localparam logic signed [127:0] MX = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MN = -128'sh8000_0000_0000_0000;

  typedef struct {
    logic [1:0]  ch;
    logic [63:0] rp;
    logic        ex;
    logic        st;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          rdy_lo_from = -1;
  int          rdy_lo_to = -1;
  logic [63:0] m_gam[4];
  logic [31:0] m_term[4];
  bit          stall_prev = 0;
  logic [63:0] hold_ref;
  logic [1:0]  hold_ch;
  logic        hold_ex, hold_st;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic signed [127:0] m_mul(input logic signed [127:0] x,
                                                input logic signed [127:0] y,
                                                inout logic st);
    logic signed [127:0] p;
    p = (x * y) >>> 32;
    if (p > MX) begin p = MX; st = 1'b1; end
    else if (p < MN) begin p = MN; st = 1'b1; end
    return p;
  endfunction

  function automatic exp_t model(input logic [1:0] ch, input logic [31:0] price,
                                 input logic [31:0] t, input logic [63:0] q,
                                 input logic [63:0] sig);
    exp_t e;
    logic st;
    logic signed [127:0] tau, pf, a, b, adj, r, qx, sx, gx;
    st  = 1'b0;
    e.ex = (t >= m_term[ch]);
    tau = 0;
    if (!e.ex) tau = $signed({64'd0, m_term[ch] - t, 32'd0});
    pf  = $signed({64'd0, price, 32'd0});
    qx  = $signed({{64{q[63]}}, q});
    sx  = $signed({{64{sig[63]}}, sig});
    gx  = $signed({{64{m_gam[ch][63]}}, m_gam[ch]});
    a   = m_mul(qx, gx, st);
    b   = m_mul(a, sx, st);
    adj = m_mul(b, tau, st);
    r   = pf - adj;
    if (r < 0) begin r = 0; st = 1'b1; end
    else if (r > MX) begin r = MX; st = 1'b1; end
    e.ch = ch; e.rp = r[63:0]; e.st = st; e.acc_cyc = 0; e.chk_lat = 0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [1:0] ch, input logic [63:0] rp,
                              input logic ex, input logic st, input bit lat);
    exp_t e;
    e.ch = ch; e.rp = rp; e.ex = ex; e.st = st; e.acc_cyc = 0; e.chk_lat = lat;
    return e;
  endfunction

  // One clock cycle; inputs are already driven (posedge + 1).
  task automatic step(input exp_t nxt, output bit acc);
    exp_t e;
    i_ready = !(cyc >= rdy_lo_from && cyc < rdy_lo_to);
    @(negedge i_clk);
    chk("o_ready", 64'(o_ready), 64'(!o_valid || i_ready));
    if (stall_prev) begin
      chk("hold_valid", 64'(o_valid), 64'd1);
      chk("hold_ref", o_ref_price, hold_ref);
      chk("hold_ch", 64'(o_channel), 64'(hold_ch));
      chk("hold_flags", 64'({o_expired, o_sat}), 64'({hold_ex, hold_st}));
    end
    stall_prev = o_valid && !i_ready;
    hold_ref = o_ref_price; hold_ch = o_channel; hold_ex = o_expired; hold_st = o_sat;
    acc = i_valid && o_ready;
    if (acc) begin
      e = nxt;
      e.acc_cyc = cyc;
      sbq.push_back(e);
    end
    if (o_valid && i_ready) begin
      if (sbq.size() == 0) chk("spurious_out", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        chk("channel", 64'(o_channel), 64'(e.ch));
        chk("ref_price", o_ref_price, e.rp);
        chk("expired", 64'(o_expired), 64'(e.ex));
        chk("sat", 64'(o_sat), 64'(e.st));
        if (e.chk_lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd4);
      end
    end
    @(posedge i_clk);
    #1;
    if (i_cfg_we) begin
      m_gam[i_cfg_ch]  = i_cfg_risk_factor;
      m_term[i_cfg_ch] = i_cfg_terminal_time;
      i_cfg_we = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit acc;
    i_valid = 1'b0;
    for (int k = 0; k < n; k++) step(mk(0, 0, 0, 0, 0), acc);
  endtask

  task automatic drain();
    int n = 0;
    bit acc;
    i_valid = 1'b0;
    while (sbq.size() != 0 && n < 60) begin
      step(mk(0, 0, 0, 0, 0), acc);
      n++;
    end
    if (sbq.size() != 0) chk("drain_timeout", 64'(sbq.size()), 64'd0);
  endtask

  task automatic send(input logic [1:0] ch, input logic [31:0] price, input logic [31:0] t,
                      input logic [63:0] q, input logic [63:0] sig, input exp_t e);
    bit acc;
    int n = 0;
    i_valid = 1'b1; i_channel = ch; i_curr_price = price; i_curr_time = t;
    i_inventory_state = q; i_volatility = sig;
    do begin
      step(e, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    i_valid = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] ch, input logic [63:0] g, input logic [31:0] tt);
    i_cfg_we = 1'b1; i_cfg_ch = ch; i_cfg_risk_factor = g; i_cfg_terminal_time = tt;
  endtask

  task automatic send_m(input logic [1:0] ch, input logic [31:0] price, input logic [31:0] t,
                        input logic [63:0] q, input logic [63:0] sig);
    send(ch, price, t, q, sig, model(ch, price, t, q, sig));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] qv, sv;
    i_reset_n = 1'b0; i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_risk_factor = '0;
    i_cfg_terminal_time = '0; i_valid = 1'b0; i_channel = '0; i_curr_price = '0;
    i_curr_time = '0; i_inventory_state = '0; i_volatility = '0; i_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin m_gam[c] = '0; m_term[c] = '0; end

    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ref", o_ref_price, 64'd0);
    chk("rst_ch", 64'(o_channel), 64'd0);
    chk("rst_flags", 64'({o_expired, o_sat}), 64'd0);
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    idle(1);

    // Directed cases with hand-derived results.
    set_cfg(1, HALF, 10);
    idle(1);
    send(1, 100, 6, TWO, ONE, mk(1, 64'h0000_0060_0000_0000, 0, 0, 1));
    drain();
    send(1, 100, 12, TWO, ONE, mk(1, 64'h0000_0064_0000_0000, 1, 0, 1));
    send(1, 100, 10, TWO, ONE, mk(1, 64'h0000_0064_0000_0000, 1, 0, 0));
    send(1, 100, 6, 64'hFFFF_FFFE_0000_0000, ONE, mk(1, 64'h0000_0068_0000_0000, 0, 0, 0));
    set_cfg(3, ONE, 10);
    idle(1);
    send(3, 100, 6, 64'h0000_03E8_0000_0000, ONE, mk(3, 64'd0, 0, 1, 0));
    send(0, 55, 0, TWO, ONE, mk(0, 64'h0000_0037_0000_0000, 1, 0, 0));
    drain();

    // Back-to-back on all channels with a 3-cycle downstream stall.
    rdy_lo_from = cyc + 5;
    rdy_lo_to   = cyc + 8;
    for (int i = 0; i < 8; i++) begin
      qv = 64'((longint'($urandom_range(0, 16)) - 8) <<< 29);
      sv = 64'(longint'($urandom_range(1, 8)) <<< 29);
      send_m(2'(i % 4), 32'($urandom_range(50, 500)), 32'($urandom_range(0, 12)), qv, sv);
    end
    drain();
    rdy_lo_from = -1;
    rdy_lo_to   = -1;

    // Config write racing an acceptance on the same channel.
    set_cfg(2, HALF, 10);
    idle(1);
    set_cfg(2, ONE, 10);
    send(2, 100, 6, TWO, ONE, mk(2, 64'h0000_0060_0000_0000, 0, 0, 0));
    send(2, 100, 6, TWO, ONE, mk(2, 64'h0000_005C_0000_0000, 0, 0, 0));
    drain();

    // Reset with transactions in flight.
    for (int i = 0; i < 5; i++) send_m(1, 32'(100 + i), 6, TWO, ONE);
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    i_reset_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_ref", o_ref_price, 64'd0);
    sbq.delete();
    stall_prev = 0;
    for (int c = 0; c < 4; c++) begin m_gam[c] = '0; m_term[c] = '0; end
    @(posedge i_clk); @(posedge i_clk); #1;
    i_reset_n = 1'b1;
    idle(8);
    send(1, 100, 6, TWO, ONE, mk(1, 64'h0000_0064_0000_0000, 1, 0, 1));
    send(3, 100, 6, 64'h0000_03E8_0000_0000, ONE, mk(3, 64'h0000_0064_0000_0000, 1, 0, 0));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
